// File: rtl/shot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shot_pkg
//  Description : Shared types and constants for the multi-shot projectile
//                pool: direction and slot-state enums, fixed-point and pixel
//                widths, and the diagonal velocity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package shot_pkg;

  // Fixed-point position/velocity width and pixel coordinate width.
  localparam int FP_W  = 32;
  localparam int PIX_W = 11;

  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_NE = 3'd1,
    DIR_E  = 3'd2,
    DIR_SE = 3'd3,
    DIR_S  = 3'd4,
    DIR_SW = 3'd5,
    DIR_W  = 3'd6,
    DIR_NW = 3'd7
  } dir_e;

  typedef enum logic [0:0] {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_e;

  // Per-axis diagonal magnitude: speed / sqrt(2), approximated as 181/256.
  function automatic int diag_vel(input int speed);
    return (speed * 181) >>> 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shot_slot.sv
`default_nettype none
// ============================================================================
//  Module      : shot_slot
//  Description : One projectile slot. Two-state FSM (IDLE/FLYING) holding a
//                signed fixed-point position and velocity; moves once per
//                frame, parks itself when leaving the live area or on a hit.
//  Ports       : clk, resetN       clock / async active-low reset
//                load_i            launch this slot (only honoured when IDLE)
//                start_*_i, vel_*_i launch position and velocity (fixed point)
//                sof_i             start-of-frame movement strobe
//                collision_i       hit: force IDLE, overrides movement
//                active_o          slot is FLYING
//                x_o, y_o          registered pixel position
//  Revision    : 1.0  initial release
// ============================================================================
module shot_slot
  import shot_pkg::*;
#(
  parameter int FP_MULT = 64,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 639,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 479,
  parameter int PARK    = 781
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    load_i,
  input  logic                    sof_i,
  input  logic                    collision_i,
  input  logic signed [FP_W-1:0]  start_x_i,
  input  logic signed [FP_W-1:0]  start_y_i,
  input  logic signed [FP_W-1:0]  vel_x_i,
  input  logic signed [FP_W-1:0]  vel_y_i,
  output logic                    active_o,
  output logic [PIX_W-1:0]        x_o,
  output logic [PIX_W-1:0]        y_o
);

  localparam int SHIFT = $clog2(FP_MULT);
  localparam logic signed [FP_W-1:0] PARK_FP = FP_W'(PARK * FP_MULT);
  localparam logic signed [FP_W-1:0] X_LO    = FP_W'(X_MIN * FP_MULT);
  localparam logic signed [FP_W-1:0] X_HI    = FP_W'(X_MAX * FP_MULT);
  localparam logic signed [FP_W-1:0] Y_LO    = FP_W'(Y_MIN * FP_MULT);
  localparam logic signed [FP_W-1:0] Y_HI    = FP_W'(Y_MAX * FP_MULT);

  slot_state_e              state_q, state_d;
  logic signed [FP_W-1:0]   px_q, px_d, py_q, py_d;
  logic signed [FP_W-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic signed [FP_W-1:0]   nx, ny;
  logic                     oob;
  logic [PIX_W-1:0]         ox_q, ox_d, oy_q, oy_d;

  // State register (state, position, velocity, registered pixel outputs).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= SLOT_IDLE;
      px_q    <= PARK_FP;
      py_q    <= PARK_FP;
      vx_q    <= '0;
      vy_q    <= '0;
      ox_q    <= PIX_W'(PARK);
      oy_q    <= PIX_W'(PARK);
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    nx      = px_q + vx_q;
    ny      = py_q + vy_q;
    oob     = (nx < X_LO) || (nx > X_HI) || (ny < Y_LO) || (ny > Y_HI);
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    case (state_q)
      SLOT_IDLE: begin
        // A freshly loaded slot does not move on a coincident frame strobe.
        if (load_i) begin
          state_d = SLOT_FLYING;
          px_d    = start_x_i;
          py_d    = start_y_i;
          vx_d    = vel_x_i;
          vy_d    = vel_y_i;
        end
      end
      SLOT_FLYING: begin
        if (collision_i || (sof_i && oob)) begin
          state_d = SLOT_IDLE;
          px_d    = PARK_FP;
          py_d    = PARK_FP;
          vx_d    = '0;
          vy_d    = '0;
        end else if (sof_i) begin
          px_d = nx;
          py_d = ny;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  // Output logic: pixel outputs are registered from the next state so they
  // change on the same edge as the state; arithmetic shift floors negatives.
  always_comb begin
    if (state_d == SLOT_FLYING) begin
      ox_d = PIX_W'(px_d >>> SHIFT);
      oy_d = PIX_W'(py_d >>> SHIFT);
    end else begin
      ox_d = PIX_W'(PARK);
      oy_d = PIX_W'(PARK);
    end
  end

  assign active_o = (state_q == SLOT_FLYING);
  assign x_o      = ox_q;
  assign y_o      = oy_q;

endmodule
`default_nettype wire

// File: rtl/multi_shot_pool.sv
`default_nettype none
// ============================================================================
//  Module      : multi_shot_pool
//  Description : Pool of NUM_SHOTS projectile slots with trigger edge
//                detection, lowest-index-idle allocation and a frame-based
//                fire cooldown.
//  Ports       : clk, resetN                  clock / async active-low reset
//                startOfFrame                 one-cycle frame strobe
//                triggerShot                  fire request on rising edge
//                shotDirection                0=N .. 7=NW
//                player_topLeftX/Y            spawn pixel position (signed)
//                shotCollision                per-slot hit, forces IDLE
//                topLeftX/Y                   per-slot pixel pos, 11b per slot
//                shotActive                   per-slot FLYING flag
//                fireDenied                   one-cycle pulse on rejected fire
//  Revision    : 1.0  initial release
// ============================================================================
module multi_shot_pool
  import shot_pkg::*;
#(
  parameter int NUM_SHOTS       = 4,
  parameter int SPEED           = 100,
  parameter int FP_MULT         = 64,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
  parameter int PARK            = 781
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         triggerShot,
  input  logic [2:0]                   shotDirection,
  input  logic signed [PIX_W-1:0]      player_topLeftX,
  input  logic signed [PIX_W-1:0]      player_topLeftY,
  input  logic [NUM_SHOTS-1:0]         shotCollision,
  output logic [NUM_SHOTS*PIX_W-1:0]   topLeftX,
  output logic [NUM_SHOTS*PIX_W-1:0]   topLeftY,
  output logic [NUM_SHOTS-1:0]         shotActive,
  output logic                         fireDenied
);

  localparam int SHIFT  = $clog2(FP_MULT);
  localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic signed [FP_W-1:0] SPD = FP_W'(SPEED);
  localparam logic signed [FP_W-1:0] DG  = FP_W'(diag_vel(SPEED));

  logic                    trig_q;
  logic                    armed_q;
  logic                    denied_q;
  logic [COOL_W-1:0]       cool_q, cool_d;
  logic [NUM_SHOTS-1:0]    sel, load;
  logic                    found, fire_req, accept;
  logic signed [FP_W-1:0]  start_x, start_y, vel_x, vel_y;

  // armed_q only rises once the trigger has been seen low, so a trigger held
  // through reset release is not mistaken for a fresh press.
  assign fire_req = triggerShot & ~trig_q & armed_q;
  assign accept   = fire_req & (cool_q == '0) & found;
  assign load     = sel & {NUM_SHOTS{accept}};

  // Lowest-index IDLE slot, judged on registered slot state.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (!shotActive[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    if (accept)
      cool_d = COOL_W'(COOLDOWN_FRAMES);
    else if (startOfFrame && (cool_q != '0))
      cool_d = cool_q - COOL_W'(1);
    else
      cool_d = cool_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      trig_q   <= 1'b0;
      armed_q  <= 1'b0;
      denied_q <= 1'b0;
      cool_q   <= '0;
    end else begin
      trig_q   <= triggerShot;
      armed_q  <= armed_q | ~triggerShot;
      denied_q <= fire_req & ~accept;
      cool_q   <= cool_d;
    end
  end

  assign fireDenied = denied_q;

  assign start_x = {{(FP_W-PIX_W){player_topLeftX[PIX_W-1]}}, player_topLeftX} <<< SHIFT;
  assign start_y = {{(FP_W-PIX_W){player_topLeftY[PIX_W-1]}}, player_topLeftY} <<< SHIFT;

  // Screen convention: north is negative Y, east is positive X.
  always_comb begin
    vel_x = '0;
    vel_y = '0;
    case (dir_e'(shotDirection))
      DIR_N:  begin vel_x = '0;   vel_y = -SPD; end
      DIR_NE: begin vel_x = DG;   vel_y = -DG;  end
      DIR_E:  begin vel_x = SPD;  vel_y = '0;   end
      DIR_SE: begin vel_x = DG;   vel_y = DG;   end
      DIR_S:  begin vel_x = '0;   vel_y = SPD;  end
      DIR_SW: begin vel_x = -DG;  vel_y = DG;   end
      DIR_W:  begin vel_x = -SPD; vel_y = '0;   end
      DIR_NW: begin vel_x = -DG;  vel_y = -DG;  end
      default: begin vel_x = '0;  vel_y = '0;   end
    endcase
  end

  for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
    shot_slot #(
      .FP_MULT (FP_MULT),
      .X_MIN   (X_MIN),
      .X_MAX   (X_MAX),
      .Y_MIN   (Y_MIN),
      .Y_MAX   (Y_MAX),
      .PARK    (PARK)
    ) u_slot (
      .clk         (clk),
      .resetN      (resetN),
      .load_i      (load[i]),
      .sof_i       (startOfFrame),
      .collision_i (shotCollision[i]),
      .start_x_i   (start_x),
      .start_y_i   (start_y),
      .vel_x_i     (vel_x),
      .vel_y_i     (vel_y),
      .active_o    (shotActive[i]),
      .x_o         (topLeftX[i*PIX_W +: PIX_W]),
      .y_o         (topLeftY[i*PIX_W +: PIX_W])
    );
  end

endmodule
`default_nettype wire
